// File: rtl/lbp_pkg.sv
// Shared constants, state encoding and the border test for the LBP image host.
package lbp_pkg;
    localparam int IMG_W  = 128;
    localparam int IMG_H  = 128;
    localparam int AW     = 14;
    localparam int DW     = 8;
    localparam int EXP_WR = 15876;
    localparam int COL_W  = $clog2(IMG_W);
    localparam int ROW_W  = AW - COL_W;
    localparam int NPIX   = IMG_W * IMG_H;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SERVE = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // True when the address sits in the outer one-pixel frame of the image.
    function automatic logic is_border(input logic [AW-1:0] a);
        logic [COL_W-1:0] col;
        logic [ROW_W-1:0] row;
        col = a[COL_W-1:0];
        row = a[AW-1:COL_W];
        return (col == '0) || (col == COL_W'(IMG_W - 1)) ||
               (row == '0) || (row == ROW_W'(IMG_H - 1));
    endfunction
endpackage

// File: rtl/lbp_img_ram.sv
// Simple one-write one-read RAM. REG_RD selects a registered (1-cycle) or
// combinational read port. Contents are never cleared.
module lbp_img_ram #(
    parameter int AW     = 14,
    parameter int DW     = 8,
    parameter bit REG_RD = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);
    logic [DW-1:0] mem [0:(1<<AW)-1];

    // Write port.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    generate
        if (REG_RD) begin : g_reg_rd
            logic [DW-1:0] rdata_q;
            // Registered read; the output register alone is reset.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) rdata_q <= '0;
                else     rdata_q <= mem[raddr];
            end
            assign rdata = rdata_q;
        end else begin : g_async_rd
            logic unused_rst;
            assign unused_rst = rst;
            assign rdata      = mem[raddr];
        end
    endgenerate
endmodule

// File: rtl/lbp_img_host.sv
// Memory-side responder for the LBP engine: loads the gray image from a
// pixel stream, serves zero-latency reads, captures and checks results.
module lbp_img_host
    import lbp_pkg::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          pix_valid,
    input  logic [DW-1:0] pix_data,
    input  logic          gray_req,
    input  logic [AW-1:0] gray_addr,
    output logic          gray_ready,
    output logic [DW-1:0] gray_data,
    input  logic          lbp_valid,
    input  logic [AW-1:0] lbp_addr,
    input  logic [DW-1:0] lbp_data,
    input  logic          finish,
    input  logic [AW-1:0] res_rd_addr,
    output logic [DW-1:0] res_rd_data,
    output logic [AW-1:0] wr_count,
    output logic          done,
    output logic          err_border,
    output logic          err_proto,
    output logic          err_count
);
    state_e        state_q, state_d;
    logic [AW-1:0] ptr_q, ptr_d;
    logic [AW-1:0] wrc_q, wrc_d;
    logic          eb_q, eb_d;
    logic          ep_q, ep_d;
    logic          img_we, res_we;

    // Reads are served whether or not gray_req is asserted.
    logic unused_req;
    assign unused_req = gray_req;

    // State, load pointer, write counter and sticky error flags.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_LOAD;
            ptr_q   <= '0;
            wrc_q   <= '0;
            eb_q    <= 1'b0;
            ep_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            wrc_q   <= wrc_d;
            eb_q    <= eb_d;
            ep_q    <= ep_d;
        end
    end

    // Next-state, RAM write enables and flag updates.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        wrc_d   = wrc_q;
        eb_d    = eb_q;
        ep_d    = ep_q;
        img_we  = 1'b0;
        res_we  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                if (pix_valid) begin
                    img_we = 1'b1;
                    ptr_d  = ptr_q + 1'b1;  // wraps to 0 after the last pixel
                    if (ptr_q == AW'(NPIX - 1)) state_d = ST_SERVE;
                end
                if (lbp_valid) ep_d = 1'b1;
            end
            ST_SERVE: begin
                if (lbp_valid) begin
                    res_we = 1'b1;
                    if (wrc_q != '1) wrc_d = wrc_q + 1'b1;
                    if (is_border(lbp_addr)) eb_d = 1'b1;
                end
                if (finish) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (lbp_valid) ep_d = 1'b1;
            end
            default: state_d = ST_LOAD;
        endcase
    end

    lbp_img_ram #(.AW(AW), .DW(DW), .REG_RD(1'b0)) u_img_ram (
        .clk   (clk),
        .rst   (reset),
        .we    (img_we),
        .waddr (ptr_q),
        .wdata (pix_data),
        .raddr (gray_addr),
        .rdata (gray_data)
    );

    lbp_img_ram #(.AW(AW), .DW(DW), .REG_RD(1'b1)) u_res_ram (
        .clk   (clk),
        .rst   (reset),
        .we    (res_we),
        .waddr (lbp_addr),
        .wdata (lbp_data),
        .raddr (res_rd_addr),
        .rdata (res_rd_data)
    );

    assign gray_ready = (state_q != ST_LOAD);
    assign done       = (state_q == ST_DONE);
    assign wr_count   = wrc_q;
    assign err_border = eb_q;
    assign err_proto  = ep_q;
    assign err_count  = done && (wrc_q != AW'(EXP_WR));
endmodule

// File: tb/tb_lbp_img_host.sv
// Randomized bench for lbp_img_host with an in-bench behavioural model.
module tb_lbp_img_host;
    logic        clk;
    logic        reset;
    logic        pix_valid;
    logic [7:0]  pix_data;
    logic        gray_req;
    logic [13:0] gray_addr;
    logic        gray_ready;
    logic [7:0]  gray_data;
    logic        lbp_valid;
    logic [13:0] lbp_addr;
    logic [7:0]  lbp_data;
    logic        finish;
    logic [13:0] res_rd_addr;
    logic [7:0]  res_rd_data;
    logic [13:0] wr_count;
    logic        done;
    logic        err_border;
    logic        err_proto;
    logic        err_count;

    int total = 0;
    int bad   = 0;

    lbp_img_host dut (
        .clk(clk), .reset(reset), .pix_valid(pix_valid), .pix_data(pix_data),
        .gray_req(gray_req), .gray_addr(gray_addr), .gray_ready(gray_ready),
        .gray_data(gray_data), .lbp_valid(lbp_valid), .lbp_addr(lbp_addr),
        .lbp_data(lbp_data), .finish(finish), .res_rd_addr(res_rd_addr),
        .res_rd_data(res_rd_data), .wr_count(wr_count), .done(done),
        .err_border(err_border), .err_proto(err_proto), .err_count(err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [7:0] img_m [16384];
    logic [7:0] res_m [16384];
    bit         res_w [16384];
    int         n_loaded;   // pixels received since reset; 16384 means image ready
    bit         done_m;
    int         wrc_m;
    bit         eb_m, ep_m;
    logic [7:0] rd_exp_m;
    bit         rd_ok_m;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            n_loaded <= 0;
            done_m   <= 1'b0;
            wrc_m    <= 0;
            eb_m     <= 1'b0;
            ep_m     <= 1'b0;
            rd_exp_m <= 8'h00;
            rd_ok_m  <= 1'b1;
        end else begin
            rd_exp_m <= res_m[res_rd_addr];
            rd_ok_m  <= res_w[res_rd_addr];
            if (n_loaded < 16384) begin
                if (pix_valid) begin
                    img_m[n_loaded] <= pix_data;
                    n_loaded <= n_loaded + 1;
                end
                if (lbp_valid) ep_m <= 1'b1;
            end else if (!done_m) begin
                if (lbp_valid) begin
                    res_m[lbp_addr] <= lbp_data;
                    res_w[lbp_addr] <= 1'b1;
                    wrc_m <= (wrc_m == 16383) ? wrc_m : wrc_m + 1;
                    if ((int'(lbp_addr) % 128 == 0) || (int'(lbp_addr) % 128 == 127) ||
                        (int'(lbp_addr) / 128 == 0) || (int'(lbp_addr) / 128 == 127))
                        eb_m <= 1'b1;
                end
                if (finish) done_m <= 1'b1;
            end else begin
                if (lbp_valid) ep_m <= 1'b1;
            end
        end
    end

    // Compare DUT against the model every cycle, mid-period.
    always @(negedge clk) begin
        check("gray_ready", 32'(gray_ready), 32'(n_loaded == 16384));
        if (n_loaded == 16384) check("gray_data", 32'(gray_data), 32'(img_m[gray_addr]));
        if (rd_ok_m) check("res_rd_data", 32'(res_rd_data), 32'(rd_exp_m));
        check("wr_count", 32'(wr_count), 32'(wrc_m));
        check("done", 32'(done), 32'(done_m));
        check("err_border", 32'(err_border), 32'(eb_m));
        check("err_proto", 32'(err_proto), 32'(ep_m));
        check("err_count", 32'(err_count), 32'(done_m && (wrc_m != 15876)));
    end

    // ---------------- stimulus ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic load_image(input bit ramp);
        for (int a = 0; a < 16384; a++) begin
            pix_valid = 1'b1;
            pix_data  = ramp ? 8'(a) : 8'($urandom);
            gray_req  = (a % 64 == 0);
            gray_addr = 14'd5;
            if (a == 16383) check("ready_before_last", 32'(gray_ready), 32'd0);
            tick();
        end
        pix_valid = 1'b0;
        gray_req  = 1'b0;
        check("ready_after_last", 32'(gray_ready), 32'd1);
    endtask

    initial begin
        reset = 1'b1; pix_valid = 1'b0; pix_data = '0; gray_req = 1'b0; gray_addr = '0;
        lbp_valid = 1'b0; lbp_addr = '0; lbp_data = '0; finish = 1'b0; res_rd_addr = '0;
        repeat (2) tick();
        check("rst_gray_ready", 32'(gray_ready), 32'd0);
        check("rst_wr_count", 32'(wr_count), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_err_proto", 32'(err_proto), 32'd0);
        check("rst_res_rd_data", 32'(res_rd_data), 32'd0);
        reset = 1'b0;
        tick();

        // Partial load with a stray result write, then reset mid-load.
        for (int a = 0; a < 8000; a++) begin
            pix_valid = 1'b1;
            pix_data  = 8'($urandom);
            lbp_valid = (a == 100);
            tick();
        end
        pix_valid = 1'b0; lbp_valid = 1'b0;
        check("load_err_proto", 32'(err_proto), 32'd1);
        check("partial_not_ready", 32'(gray_ready), 32'd0);
        reset = 1'b1;
        #1;
        check("midrst_gray_ready", 32'(gray_ready), 32'd0);
        check("midrst_wr_count", 32'(wr_count), 32'd0);
        check("midrst_err_proto", 32'(err_proto), 32'd0);
        tick();
        reset = 1'b0;
        tick();

        // Ramp image; reads of address 5 issued during load are ignored.
        load_image(1'b1);
        gray_addr = 14'd5;      #1; check("gray_5", 32'(gray_data), 32'h05);
        gray_addr = 14'h0181;   #1; check("gray_181", 32'(gray_data), 32'h81);
        check("load_no_proto", 32'(err_proto), 32'd0);
        check("load_no_border", 32'(err_border), 32'd0);

        // Engine-like pass over every interior pixel, with random gaps and reads.
        for (int r = 1; r < 127; r++) begin
            for (int c = 1; c < 127; c++) begin
                lbp_valid   = 1'b1;
                lbp_addr    = 14'(r * 128 + c);
                lbp_data    = 8'($urandom);
                gray_req    = 1'b1;
                gray_addr   = 14'($urandom);
                res_rd_addr = 14'($urandom);
                tick();
                if ($urandom_range(0, 7) == 0) begin
                    lbp_valid = 1'b0;
                    tick();
                end
            end
        end
        lbp_valid = 1'b0; gray_req = 1'b0;
        finish = 1'b1; tick(); finish = 1'b0; tick();
        check("full_done", 32'(done), 32'd1);
        check("full_wr_count", 32'(wr_count), 32'd15876);
        check("full_err_count", 32'(err_count), 32'd0);
        check("full_err_border", 32'(err_border), 32'd0);
        for (int i = 0; i < 200; i++) begin
            res_rd_addr = 14'($urandom_range(1, 126) * 128 + $urandom_range(1, 126));
            gray_addr   = 14'($urandom);
            tick();
        end

        // Fresh random image, border write, write+finish, late write.
        reset = 1'b1; tick(); reset = 1'b0; tick();
        load_image(1'b0);
        lbp_valid = 1'b1; lbp_addr = 14'h0080; lbp_data = 8'hA5; res_rd_addr = 14'h0080;
        tick();
        lbp_valid = 1'b0;
        check("border_flag", 32'(err_border), 32'd1);
        check("border_count", 32'(wr_count), 32'd1);
        tick();
        check("border_readback", 32'(res_rd_data), 32'hA5);
        lbp_valid = 1'b1; finish = 1'b1; lbp_addr = 14'h0105; lbp_data = 8'h3C;
        tick();
        lbp_valid = 1'b0; finish = 1'b0;
        check("fin_done", 32'(done), 32'd1);
        check("fin_count", 32'(wr_count), 32'd2);
        lbp_valid = 1'b1; lbp_addr = 14'h0200; lbp_data = 8'hFF;
        tick();
        lbp_valid = 1'b0;
        check("late_proto", 32'(err_proto), 32'd1);
        check("late_count", 32'(wr_count), 32'd2);
        check("late_err_count", 32'(err_count), 32'd1);
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
